// File: rtl/freq_sweep_if.sv
// Bundle between the resonant-frequency search controller and its ADC front end / frequency generator.
// The master side supplies control and samples; the slave side is the controller.
interface freq_sweep_if #(
    parameter int FREQ_W   = 20,
    parameter int ADC_W    = 12,
    parameter int AVG_LOG2 = 3
);
    logic                      swipt_alive;
    logic                      start;
    logic                      fine_en;
    logic                      adc_valid;
    logic [ADC_W-1:0]          adc;
    logic [FREQ_W-1:0]         new_freq;
    logic [FREQ_W-1:0]         best_freq;
    logic [ADC_W+AVG_LOG2-1:0] best_mag;
    logic                      busy;
    logic                      done;

    modport master (
        output swipt_alive, start, fine_en, adc_valid, adc,
        input  new_freq, best_freq, best_mag, busy, done
    );

    modport slave (
        input  swipt_alive, start, fine_en, adc_valid, adc,
        output new_freq, best_freq, best_mag, busy, done
    );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Resonant-frequency search: coarse sweep, optional fine sweep around the coarse best,
// averaging 2^AVG_LOG2 rectified ADC samples per point and keeping the strict maximum.
module freq_sweep_ctrl #(
    parameter int                FREQ_W      = 20,
    parameter int                ADC_W       = 12,
    parameter int                AVG_LOG2    = 3,
    parameter int                CNT_W       = 24,
    parameter logic [FREQ_W-1:0] FREQ_START  = 20'h88B8,
    parameter logic [FREQ_W-1:0] FREQ_STOP   = 20'hAFC8,
    parameter logic [FREQ_W-1:0] STEP_COARSE = 20'h1F4,
    parameter logic [FREQ_W-1:0] STEP_FINE   = 20'h32,
    parameter logic [CNT_W-1:0]  STARTUP_CYC = 24'h30D40,
    parameter logic [CNT_W-1:0]  SETTLE_CYC  = 24'h30D40
) (
    input  logic         clk,
    input  logic         rst,
    freq_sweep_if.slave  bus
);
    localparam int SUM_W = ADC_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] LAST_SMP = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STARTUP = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_EVAL    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [SUM_W-1:0]  acc;
    logic [AVG_LOG2:0] smp;
    logic              phase;     // 0 = coarse, 1 = fine
    logic              fine_lat;
    logic [FREQ_W-1:0] hi;
    logic [FREQ_W-1:0] new_freq;
    logic [FREQ_W-1:0] best_freq;
    logic [SUM_W-1:0]  best_mag;

    logic [ADC_W-1:0]  mag;
    logic              better;
    logic [FREQ_W-1:0] bf;
    logic [SUM_W-1:0]  bm;
    logic [FREQ_W:0]   nxt;
    logic [FREQ_W:0]   bf_up;
    logic [FREQ_W-1:0] fine_lo;
    logic [FREQ_W-1:0] fine_hi;
    logic              abort;

    // Ones-complement rectification keeps the metric in ADC_W bits (0x000 and 0xFFF both map to 0).
    assign mag    = bus.adc[ADC_W-1] ? ~bus.adc : bus.adc;
    assign abort  = (state != S_IDLE) && (!bus.start || !bus.swipt_alive);

    // EVAL arithmetic is done one bit wider so neither the step nor the fine window can wrap.
    assign better = acc > best_mag;
    assign bf     = better ? new_freq : best_freq;
    assign bm     = better ? acc : best_mag;
    assign nxt    = {1'b0, new_freq} + {1'b0, (phase ? STEP_FINE : STEP_COARSE)};
    assign bf_up  = {1'b0, bf} + {1'b0, STEP_COARSE};
    assign fine_lo = ({1'b0, bf} >= ({1'b0, FREQ_START} + {1'b0, STEP_COARSE}))
                   ? (bf - STEP_COARSE) : FREQ_START;
    assign fine_hi = (bf_up > {1'b0, FREQ_STOP}) ? FREQ_STOP : bf_up[FREQ_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            smp       <= '0;
            phase     <= 1'b0;
            fine_lat  <= 1'b0;
            hi        <= FREQ_STOP;
            new_freq  <= FREQ_START;
            best_freq <= FREQ_START;
            best_mag  <= '0;
        end else if (abort) begin
            state    <= S_IDLE;
            new_freq <= best_freq;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && bus.swipt_alive) begin
                        new_freq  <= FREQ_START;
                        best_freq <= FREQ_START;
                        best_mag  <= '0;
                        fine_lat  <= bus.fine_en;
                        phase     <= 1'b0;
                        hi        <= FREQ_STOP;
                        cnt       <= STARTUP_CYC;
                        state     <= S_STARTUP;
                    end
                end
                S_STARTUP, S_SETTLE: begin
                    if (cnt == '0) begin
                        acc   <= '0;
                        smp   <= '0;
                        state <= S_MEASURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (bus.adc_valid) begin
                        acc <= acc + SUM_W'(mag);
                        smp <= smp + 1'b1;
                        if (smp == LAST_SMP) state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    best_freq <= bf;
                    best_mag  <= bm;
                    if (nxt <= {1'b0, hi}) begin
                        new_freq <= nxt[FREQ_W-1:0];
                        cnt      <= SETTLE_CYC;
                        state    <= S_SETTLE;
                    end else if (!phase && fine_lat) begin
                        phase    <= 1'b1;
                        hi       <= fine_hi;
                        new_freq <= fine_lo;
                        cnt      <= SETTLE_CYC;
                        state    <= S_SETTLE;
                    end else begin
                        new_freq <= bf;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Held until start drops, which the abort path handles.
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.new_freq  = new_freq;
    assign bus.best_freq = best_freq;
    assign bus.best_mag  = best_mag;
    assign bus.busy      = (state == S_STARTUP) || (state == S_SETTLE) ||
                           (state == S_MEASURE) || (state == S_EVAL);
    assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Scoreboard bench for freq_sweep_ctrl: expected sweep results are queued by the stimulus
// and checked by a monitor on each rising done; aborts and resets are checked in line.
module tb_freq_sweep_ctrl;
    logic clk;
    logic rst;

    freq_sweep_if #(.FREQ_W(20), .ADC_W(12), .AVG_LOG2(1)) bus ();

    freq_sweep_ctrl #(
        .FREQ_W(20), .ADC_W(12), .AVG_LOG2(1), .CNT_W(24),
        .FREQ_START(20'd100), .FREQ_STOP(20'd140),
        .STEP_COARSE(20'd10), .STEP_FINE(20'd2),
        .STARTUP_CYC(24'd5), .SETTLE_CYC(24'd3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string name;
        int    bf;
        int    nf;
        int    bm;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   tid      = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Per-test magnitude profile as a function of the applied frequency.
    function automatic int mag_of(input int t, input int f);
        case (t)
            1: return 200 - absi(f - 120);
            2: return 200 - absi(f - 124);
            3: return 300 - absi(f - 96);
            4: return 300 - absi(f - 144);
            5: case (f)
                   100: return 50;
                   110: return 80;
                   120: return 60;
                   130: return 80;
                   default: return 0;
               endcase
            6: return 100 - absi(f - 130);
            default: return 0;
        endcase
    endfunction

    // ADC model: after any frequency change or search start, three strobes carry a large
    // bogus value (must be ignored while settling); afterwards the real value alternates
    // between the positive code and its ones-complement, which rectify to the same mag.
    initial begin
        int         quiet;
        int         last_f;
        logic       last_busy;
        logic       tog;
        logic [11:0] mv;
        quiet = 3; last_f = 100; last_busy = 1'b0; tog = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc       = '0;
        forever begin
            @(negedge clk);
            if (int'(bus.new_freq) != last_f || (bus.busy && !last_busy)) quiet = 0;
            last_f    = int'(bus.new_freq);
            last_busy = bus.busy;
            bus.adc_valid = 1'b1;
            if (quiet < 3) begin
                bus.adc = 12'h7FF;
                quiet++;
            end else begin
                mv      = 12'(mag_of(tid, last_f));
                bus.adc = tog ? mv : ~mv;
                tog     = ~tog;
            end
        end
    end

    // Monitor: each rising done pops one expected result.
    initial begin
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !done_q) begin
                chk("sb_pending", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({e.name, "_best_freq"}, int'(bus.best_freq), e.bf);
                    chk({e.name, "_new_freq"},  int'(bus.new_freq),  e.nf);
                    chk({e.name, "_best_mag"},  int'(bus.best_mag),  e.bm);
                    chk({e.name, "_busy"},      int'(bus.busy),      0);
                end
            end
            done_q = bus.done;
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_wait"}, int'(bus.done), 1);
    endtask

    task automatic wait_freq(input int f);
        int n = 0;
        while (int'(bus.new_freq) != f && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("freq_wait", int'(bus.new_freq), f);
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input string name, input int t, input bit fe,
                       input int ebf, input int enf, input int ebm);
        exp_t e;
        e.name = name; e.bf = ebf; e.nf = enf; e.bm = ebm;
        sb.push_back(e);
        tid = t;
        bus.fine_en     = fe;
        bus.swipt_alive = 1'b1;
        bus.start       = 1'b1;
        wait_done(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_new_freq"},  int'(bus.new_freq),  100);
        chk({name, "_best_freq"}, int'(bus.best_freq), 100);
        chk({name, "_best_mag"},  int'(bus.best_mag),  0);
        chk({name, "_busy"},      int'(bus.busy),      0);
        chk({name, "_done"},      int'(bus.done),      0);
    endtask

    initial begin
        rst = 1'b1;
        bus.swipt_alive = 1'b0;
        bus.start       = 1'b0;
        bus.fine_en     = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Coarse only, then hold start in DONE.
        run("coarse", 1, 1'b0, 120, 120, 400);
        repeat (10) @(negedge clk);
        chk("done_hold", int'(bus.done), 1);
        chk("done_hold_freq", int'(bus.new_freq), 120);
        release_start();
        chk("done_release", int'(bus.done), 0);

        run("fine", 2, 1'b1, 124, 124, 400);
        release_start();
        run("clamp_lo", 3, 1'b1, 100, 100, 592);
        release_start();
        run("clamp_hi", 4, 1'b1, 140, 140, 592);
        release_start();
        run("tie", 5, 1'b0, 110, 110, 160);
        release_start();

        // Drop the link while measuring at 120.
        tid = 1;
        bus.fine_en     = 1'b0;
        bus.swipt_alive = 1'b1;
        bus.start       = 1'b1;
        wait_freq(120);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.swipt_alive = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy",      int'(bus.busy),      0);
        chk("abort_done",      int'(bus.done),      0);
        chk("abort_new_freq",  int'(bus.new_freq),  110);
        chk("abort_best_freq", int'(bus.best_freq), 110);
        chk("abort_best_mag",  int'(bus.best_mag),  380);
        @(negedge clk);

        // Restart from scratch with a weaker profile: best_mag must have been cleared.
        begin
            exp_t e;
            e.name = "restart"; e.bf = 130; e.nf = 130; e.bm = 200;
            sb.push_back(e);
        end
        tid = 6;
        bus.swipt_alive = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_new_freq", int'(bus.new_freq), 100);
        chk("restart_busy",     int'(bus.busy),     1);
        wait_done("restart");
        release_start();

        // Asynchronous reset in the middle of a settle window.
        tid = 1;
        bus.start = 1'b1;
        wait_freq(110);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
